// File: rtl/dram_port_arbiter.sv
// Two-port (read/write) arbiter in front of a MIG user interface: bounded bursts
// per port, read-outstanding tracking with back-pressure and a sticky underflow flag.
module dram_port_arbiter #(
    parameter int unsigned BURST_MAX       = 8,
    parameter int unsigned OUTSTANDING_MAX = 8
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           init_calib_complete,
    input  logic           app_rdy,
    input  logic           app_wdf_rdy,
    input  logic           app_rd_data_valid,
    output logic [26:0]    app_addr,
    output logic [2:0]     app_cmd,
    output logic           app_en,
    output logic           app_wdf_wren,
    output logic           app_wdf_end,
    output logic [127:0]   app_wdf_data,
    input  logic           wr_valid,
    output logic           wr_ready,
    input  logic [23:0]    wr_addr,
    input  logic [127:0]   wr_data,
    input  logic           rd_valid,
    output logic           rd_ready,
    input  logic [23:0]    rd_addr,
    input  logic           rd_af,
    output logic [4:0]     rd_outstanding,
    output logic           rd_underflow
);

    localparam int unsigned BW = $clog2(BURST_MAX + 1);
    localparam int unsigned OW = 5;

    typedef enum logic [1:0] {
        WAIT_CAL = 2'd0,
        SERVE_RD = 2'd1,
        SERVE_WR = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
    logic [OW-1:0]   rd_out_q, rd_out_d;
    logic            rd_underflow_q, rd_underflow_d;

    logic            rd_elig;
    logic            rd_grant;
    logic            wr_grant;
    logic            burst_full;
    logic [BW-1:0]   burst_inc;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q        <= WAIT_CAL;
            burst_cnt_q    <= '0;
            rd_out_q       <= '0;
            rd_underflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            burst_cnt_q    <= burst_cnt_d;
            rd_out_q       <= rd_out_d;
            rd_underflow_q <= rd_underflow_d;
        end
    end

    // Grants: a write grant is the wr_valid/wr_ready handshake
    always_comb begin
        rd_elig    = rd_valid && !rd_af && (rd_out_q < OW'(OUTSTANDING_MAX));
        rd_ready   = (state_q == SERVE_RD) && rd_elig && app_rdy;
        wr_ready   = (state_q == SERVE_WR) && app_rdy && app_wdf_rdy;
        rd_grant   = rd_ready;
        wr_grant   = wr_ready && wr_valid;
        burst_full = (burst_cnt_q == BW'(BURST_MAX));
        burst_inc  = burst_full ? burst_cnt_q : burst_cnt_q + BW'(1);
    end

    // Next state, burst accounting and outstanding-read tracking
    always_comb begin
        state_d        = state_q;
        burst_cnt_d    = burst_cnt_q;
        rd_out_d       = rd_out_q;
        rd_underflow_d = rd_underflow_q;

        case (state_q)
            WAIT_CAL: begin
                if (init_calib_complete) begin
                    state_d = SERVE_RD;
                end
            end
            SERVE_RD: begin
                if (wr_valid && (!rd_elig || burst_full)) begin
                    state_d     = SERVE_WR;
                    burst_cnt_d = '0;
                end else if (rd_grant) begin
                    burst_cnt_d = burst_inc;
                end
            end
            SERVE_WR: begin
                if (rd_elig && (!wr_valid || burst_full)) begin
                    state_d     = SERVE_RD;
                    burst_cnt_d = '0;
                end else if (wr_grant) begin
                    burst_cnt_d = burst_inc;
                end
            end
            default: begin
                state_d     = WAIT_CAL;
                burst_cnt_d = '0;
            end
        endcase

        if (rd_grant && !app_rd_data_valid) begin
            rd_out_d = rd_out_q + OW'(1);
        end else if (!rd_grant && app_rd_data_valid) begin
            if (rd_out_q == '0) begin
                rd_underflow_d = 1'b1;
            end else begin
                rd_out_d = rd_out_q - OW'(1);
            end
        end
    end

    // MIG command path: everything is zero unless a grant is active this cycle
    always_comb begin
        app_en       = rd_grant || wr_grant;
        app_wdf_wren = wr_grant;
        app_wdf_end  = wr_grant;
        app_cmd      = rd_grant ? 3'b001 : 3'b000;
        app_wdf_data = wr_grant ? wr_data : '0;
        if (rd_grant) begin
            app_addr = {rd_addr, 3'b000};
        end else if (wr_grant) begin
            app_addr = {wr_addr, 3'b000};
        end else begin
            app_addr = '0;
        end
    end

    assign rd_outstanding = rd_out_q;
    assign rd_underflow   = rd_underflow_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed self-checking bench for dram_port_arbiter: calibration wait, burst
// alternation, address mapping, outstanding/underflow accounting and async reset.
module tb_dram_port_arbiter;

    logic           clk_in = 1'b0;
    logic           rst_in;
    logic           init_calib_complete;
    logic           app_rdy;
    logic           app_wdf_rdy;
    logic           app_rd_data_valid;
    logic [26:0]    app_addr;
    logic [2:0]     app_cmd;
    logic           app_en;
    logic           app_wdf_wren;
    logic           app_wdf_end;
    logic [127:0]   app_wdf_data;
    logic           wr_valid;
    logic           wr_ready;
    logic [23:0]    wr_addr;
    logic [127:0]   wr_data;
    logic           rd_valid;
    logic           rd_ready;
    logic [23:0]    rd_addr;
    logic           rd_af;
    logic [4:0]     rd_outstanding;
    logic           rd_underflow;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] WDATA = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;

    dram_port_arbiter #(.BURST_MAX(8), .OUTSTANDING_MAX(8)) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .init_calib_complete (init_calib_complete),
        .app_rdy             (app_rdy),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data_valid   (app_rd_data_valid),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_data        (app_wdf_data),
        .wr_valid            (wr_valid),
        .wr_ready            (wr_ready),
        .wr_addr             (wr_addr),
        .wr_data             (wr_data),
        .rd_valid            (rd_valid),
        .rd_ready            (rd_ready),
        .rd_addr             (rd_addr),
        .rd_af               (rd_af),
        .rd_outstanding      (rd_outstanding),
        .rd_underflow        (rd_underflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later
    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    int en_cnt;
    int nrd;
    int nwr;
    int first_wr;
    int last_rd;

    initial begin
        rst_in              = 1'b1;
        init_calib_complete = 1'b0;
        app_rdy             = 1'b1;
        app_wdf_rdy         = 1'b1;
        app_rd_data_valid   = 1'b0;
        wr_valid            = 1'b1;
        rd_valid            = 1'b1;
        rd_af               = 1'b0;
        rd_addr             = 24'h000123;
        wr_addr             = 24'hFFFFFF;
        wr_data             = WDATA;

        cyc();
        cyc();
        settle();
        check("rst_app_en",   128'(app_en),         128'(0));
        check("rst_rd_ready", 128'(rd_ready),       128'(0));
        check("rst_wr_ready", 128'(wr_ready),       128'(0));
        check("rst_rd_out",   128'(rd_outstanding), 128'(0));
        check("rst_underflow",128'(rd_underflow),   128'(0));

        // Calibration pending for 20 cycles with both ports requesting
        cyc();
        rst_in = 1'b0;
        en_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            settle();
            if (app_en || rd_ready || wr_ready) en_cnt++;
            cyc();
        end
        check("cal_wait_no_en", 128'(en_cnt), 128'(0));

        init_calib_complete = 1'b1;
        settle();
        check("cal_cycle_no_en", 128'(app_en), 128'(0));
        cyc();
        settle();
        check("serve_rd_entry", 128'(rd_ready), 128'(1));

        // Burst alternation with no read responses returned
        nrd = 0; nwr = 0; first_wr = -1; last_rd = -1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin
                cyc();
                settle();
            end
            if (c == 0) begin
                check("rd_app_addr", 128'(app_addr), 128'(27'h0000918));
                check("rd_app_cmd",  128'(app_cmd),  128'(3'b001));
                check("rd_app_en",   128'(app_en),   128'(1));
                check("rd_no_wren",  128'(app_wdf_wren), 128'(0));
            end
            if (rd_ready) begin
                nrd++;
                last_rd = c;
            end
            if (wr_ready) begin
                nwr++;
                if (first_wr < 0) begin
                    first_wr = c;
                    check("wr_app_addr", 128'(app_addr),     128'(27'h7FFFFF8));
                    check("wr_app_cmd",  128'(app_cmd),      128'(3'b000));
                    check("wr_wdf_end",  128'(app_wdf_end),  128'(1));
                    check("wr_wdf_wren", 128'(app_wdf_wren), 128'(1));
                    check("wr_wdf_data", app_wdf_data,       WDATA);
                end
            end
        end
        check("burst_reads",    128'(nrd),            128'(8));
        check("burst_writes",   128'(nwr),            128'(11));
        check("first_write",    128'(first_wr),       128'(9));
        check("last_read",      128'(last_rd),        128'(7));
        check("rd_out_full",    128'(rd_outstanding), 128'(8));

        // One response frees a slot: reads resume after the current write
        cyc();
        app_rd_data_valid = 1'b1;
        settle();
        check("resp_cycle_wr", 128'(wr_ready), 128'(1));
        cyc();
        app_rd_data_valid = 1'b0;
        settle();
        check("rd_out_freed",   128'(rd_outstanding), 128'(7));
        check("switch_cycle_wr",128'(wr_ready),       128'(1));
        cyc();
        settle();
        check("resume_read",    128'(rd_ready),       128'(1));
        cyc();
        settle();
        check("refill_no_read", 128'(rd_ready),       128'(0));
        check("refill_rd_out",  128'(rd_outstanding), 128'(8));
        cyc();
        settle();
        check("back_to_write",  128'(app_en & wr_ready), 128'(1));

        // Drain to 3 outstanding with both ports idle
        cyc();
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        app_rd_data_valid = 1'b1;
        repeat (4) cyc();
        cyc();
        app_rd_data_valid = 1'b0;
        settle();
        check("drain_to_3", 128'(rd_outstanding), 128'(3));
        rd_valid = 1'b1;
        settle();
        check("wr_idle_no_en", 128'(app_en), 128'(0));
        cyc();
        app_rd_data_valid = 1'b1;
        settle();
        check("grant_and_resp", 128'(rd_ready), 128'(1));
        cyc();
        rd_valid = 1'b0;
        settle();
        check("rd_out_same_cycle", 128'(rd_outstanding), 128'(3));
        cyc();
        cyc();
        cyc();
        settle();
        check("drain_to_0",   128'(rd_outstanding), 128'(0));
        check("no_underflow", 128'(rd_underflow),   128'(0));
        cyc();
        app_rd_data_valid = 1'b0;
        settle();
        check("underflow_cnt", 128'(rd_outstanding), 128'(0));
        check("underflow_set", 128'(rd_underflow),   128'(1));
        repeat (3) cyc();
        settle();
        check("underflow_sticky", 128'(rd_underflow), 128'(1));

        // Read FIFO almost full forces a switch to writes
        rd_valid = 1'b1;
        rd_af    = 1'b1;
        wr_valid = 1'b1;
        settle();
        check("af_no_read", 128'(rd_ready), 128'(0));
        cyc();
        settle();
        check("af_switch_wr", 128'(app_en & wr_ready), 128'(1));
        cyc();
        app_rdy = 1'b0;
        settle();
        check("rdy_low_no_en",  128'(app_en),          128'(0));
        check("rdy_low_no_wr",  128'(wr_ready),        128'(0));
        check("rdy_low_burst",  128'(dut.burst_cnt_q), 128'(1));
        repeat (3) cyc();
        settle();
        check("rdy_low_burst_hold", 128'(dut.burst_cnt_q), 128'(1));

        // Asynchronous reset in the middle of a write burst
        app_rdy = 1'b1;
        cyc();
        settle();
        check("pre_rst_write", 128'(app_en), 128'(1));
        #1;
        rst_in = 1'b1;
        #1;
        check("async_rst_en",    128'(app_en),         128'(0));
        check("async_rst_wren",  128'(app_wdf_wren),   128'(0));
        check("async_rst_addr",  128'(app_addr),       128'(0));
        check("async_rst_data",  app_wdf_data,         128'(0));
        check("async_rst_wr_rdy",128'(wr_ready),       128'(0));
        check("async_rst_unf",   128'(rd_underflow),   128'(0));
        cyc();
        rst_in = 1'b0;
        settle();
        check("post_rst_wait_cal", 128'(app_en | wr_ready | rd_ready), 128'(0));
        cyc();
        init_calib_complete = 1'b0;
        rd_af    = 1'b0;
        wr_valid = 1'b0;
        settle();
        check("cal_drop_ignored", 128'(rd_ready), 128'(1));
        check("cal_drop_addr",    128'(app_addr), 128'(27'h0000918));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        failures++;
        $display("FAIL timeout: got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dram_port_arbiter.md
DRAM_PORT_ARBITER -- requirements
Module: dram_port_arbiter

Interface
REQ-001 Parameter BURST_MAX, default 8: maximum consecutive grants to one port while the other port is eligible.
REQ-002 Parameter OUTSTANDING_MAX, default 8: maximum read commands issued but not yet answered.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high (ports clk_in, rst_in).
REQ-004 clk_in  input  1  MIG ui clock; all state changes on its rising edge.
REQ-005 rst_in  input  1  asynchronous, active-high reset.
REQ-006 init_calib_complete  input  1  MIG calibration done.
REQ-007 app_rdy, app_wdf_rdy  input  1 each  MIG command and write-data ready.
REQ-008 app_rd_data_valid  input  1  MIG read response beat.
REQ-009 app_addr  output  27  MIG address = {port addr[23:0], 3'b000}.
REQ-010 app_cmd  output  3  3'b000 write, 3'b001 read.
REQ-011 app_en, app_wdf_wren, app_wdf_end  output  1 each  MIG strobes.
REQ-012 app_wdf_data  output  128  write data.
REQ-013 wr_valid, wr_ready  input/output  1 each  write-request handshake.
REQ-014 wr_addr  input  24  write address in 128-bit words.
REQ-015 wr_data  input  128  write payload.
REQ-016 rd_valid, rd_ready  input/output  1 each  read-request handshake.
REQ-017 rd_addr  input  24  read address in 128-bit words.
REQ-018 rd_af  input  1  read-return FIFO almost full.
REQ-019 rd_outstanding  output  5  reads in flight.
REQ-020 rd_underflow  output  1  sticky error flag.

Function
REQ-021 States: WAIT_CAL, SERVE_RD, SERVE_WR; WAIT_CAL -> SERVE_RD on the first cycle init_calib_complete=1.
REQ-022 rd_elig = rd_valid & ~rd_af & (rd_outstanding < OUTSTANDING_MAX).
REQ-023 Read grant: rd_ready = (state==SERVE_RD) & rd_elig & app_rdy, combinational.
REQ-024 Write grant: wr_ready = (state==SERVE_WR) & app_rdy & app_wdf_rdy, combinational.
REQ-025 On a read grant: app_en=1, app_cmd=001, app_addr from rd_addr.
REQ-026 On a write grant: app_en=app_wdf_wren=app_wdf_end=1, app_cmd=000, app_addr from wr_addr, app_wdf_data=wr_data.
REQ-027 Without a grant: app_en, app_wdf_wren and app_wdf_end are 0; app_addr, app_cmd and app_wdf_data are 0.
REQ-028 In WAIT_CAL: no grants; all MIG strobes are 0.
REQ-029 burst_cnt increments on each grant in the current state; it clears to 0 on every state change and saturates at BURST_MAX.
REQ-030 SERVE_RD -> SERVE_WR when wr_valid & (~rd_elig | burst_cnt==BURST_MAX).
REQ-031 SERVE_WR -> SERVE_RD when rd_elig & (~wr_valid | burst_cnt==BURST_MAX).
REQ-032 If neither condition holds, the state is held; if both ports are idle, the state is held.
REQ-033 A transition takes effect on the next edge; a grant in the transition cycle is permitted and is counted before the clear.
REQ-034 rd_outstanding behaviour:
- +1 on a read grant.
- -1 on app_rd_data_valid.
- Unchanged when both occur in the same cycle.
REQ-035 app_rd_data_valid with rd_outstanding==0 and no simultaneous read grant: the counter stays 0 and rd_underflow is set until reset.
REQ-036 rd_outstanding never exceeds OUTSTANDING_MAX, because REQ-022 blocks further read grants.
REQ-037 init_calib_complete falling after calibration has no effect.

Reset
REQ-038 While rst_in=1, independent of clk_in:
- state=WAIT_CAL.
- burst_cnt=0, rd_outstanding=0, rd_underflow=0.
- All outputs 0.
REQ-039 Reset asserted mid-burst aborts arbitration immediately; reads in flight are discarded from the count.

Verification
REQ-040 Reset, init_calib_complete=0 for 20 cycles, both ports valid -> no app_en; SERVE_RD is entered on the cycle after calibration.
REQ-041 rd_valid and wr_valid held, all readies high, no responses returned -> 8 reads granted, state moves to SERVE_WR, then 8 writes, then return to reads only as responses free slots; rd_outstanding reads 8.
REQ-042 Read at rd_addr=0x000123 -> app_addr=0x0000918, app_cmd=001; write at wr_addr=0xFFFFFF -> app_addr=0x7FFFFF8, app_wdf_end=1.
REQ-043 rd_outstanding=3 with a read grant and app_rd_data_valid in the same cycle -> stays 3; app_rd_data_valid at 0 -> count 0, rd_underflow=1.
REQ-044 rd_af=1 in SERVE_RD with wr_valid=1 -> switch to SERVE_WR next cycle; app_rdy=0 -> no grants and burst_cnt unchanged.
REQ-045 rst_in pulsed asynchronously mid-write-burst -> outputs 0 before the next edge; state WAIT_CAL.
